key_pulse_gen: RTL and testbench
================================

KEY_PULSE_GEN -- requirements
Module: key_pulse_gen

Interface
REQ-001 SHALL provide parameter N, default 4: number of independent input channels (1..32).
REQ-002 SHALL provide parameter DB_CYCLES, default 16: consecutive stable cycles required to accept a new level (>=1).
REQ-003 SHALL provide parameter EDGE_MODE, default 0: 0 = rising edge, 1 = falling edge, 2 = both edges.
REQ-004 SHALL provide parameter REPEAT_EN, default 0: 1 enables auto-repeat while a channel is held high.
REQ-005 SHALL provide parameters REPEAT_DELAY, default 1000, and REPEAT_PERIOD, default 250: repeat timing in cycles (each >=1).
REQ-006 SHALL provide parameter OUT_ACTIVE_LOW, default 1: 1 = pulses drive 0 on an idle-high line; 0 = pulses drive 1 on an idle-low line.
REQ-007 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-008 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port in_trig, input, N bits: raw asynchronous trigger lines, one per channel.
REQ-010 SHALL have port en, input, 1 bit: pulse-generation enable.
REQ-011 SHALL have port out_pulse, output, N bits: registered one-cycle pulse per channel, polarity per OUT_ACTIVE_LOW.
REQ-012 SHALL have port out_any, output, 1 bit: registered OR of all active pulses, same polarity as out_pulse.
REQ-013 SHALL have port level, output, N bits: debounced stable level per channel, active-high.

Function
REQ-014 SHALL pass each in_trig bit through a two-flop synchronizer; both flops reset to 0.
REQ-015 SHALL keep a per-channel debounce counter that clears whenever the synchronized value equals the stable level.
REQ-016 SHALL load the synchronized value into the stable level when the counter is DB_CYCLES-1 and the values still differ, and SHALL clear the counter on the same edge.
REQ-017 SHALL detect an edge as stable != stable_d (stable_d is a one-cycle delay), qualified by EDGE_MODE.
REQ-018 SHALL make out_pulse active for exactly one cycle per qualified edge; for an input that stays clean, the pulse is registered on edge DB_CYCLES+3, counting the first edge that samples the new level as edge 1.
REQ-019 SHALL use the per-channel repeat FSM states IDLE, HOLD and REPEAT with a hold counter; the FSM is active only when REPEAT_EN=1.
REQ-020 IDLE->HOLD SHALL occur on a debounced rising level with en=1; the counter clears on entry.
REQ-021 HOLD->REPEAT SHALL occur when the counter reaches REPEAT_DELAY-1; this SHALL emit one pulse and clear the counter.
REQ-022 In REPEAT, SHALL emit one pulse each time the counter reaches REPEAT_PERIOD-1, then clear the counter.
REQ-023 Any state SHALL go to IDLE when the debounced level is 0 or en=0; the counter clears.
REQ-024 A repeat pulse coinciding with an edge pulse SHALL merge into a single one-cycle pulse.
REQ-025 With en=0, SHALL hold out_pulse and out_any inactive, while synchronizers, debounce and level keep running; an edge that occurs while en=0 SHALL NOT pulse later.
REQ-026 Channels SHALL be independent; any subset may pulse in the same cycle, and out_any reflects all of them.
REQ-027 Counters SHALL saturate or clear, never wrap; counter widths SHALL be sized with clog2 of the largest terminal count.
REQ-028 An input glitch shorter than DB_CYCLES synchronized cycles SHALL produce no level change and no pulse.

Reset
REQ-029 On rst_n low, SHALL immediately clear synchronizers, stable, stable_d, counters and level to 0, and set FSMs to IDLE.
REQ-030 On rst_n low, SHALL drive out_pulse and out_any inactive: all ones when OUT_ACTIVE_LOW=1, all zeros otherwise.
REQ-031 Reset asserted mid-debounce or mid-repeat SHALL discard progress; if an input is high at release, it SHALL be treated as a fresh rising edge after full debounce.

Verification
REQ-032 Defaults, en=1, in_trig[0] 0->1 held -> out_pulse[0]=0 for exactly one cycle at edge 19, out_any matches, level[0]=1 from edge 18.
REQ-033 in_trig[1] high for 10 cycles with DB_CYCLES=16 -> no pulse, level[1] stays 0.
REQ-034 EDGE_MODE=2, press then release on ch2 -> two single-cycle pulses, each 19 edges after its transition.
REQ-035 REPEAT_EN=1, REPEAT_DELAY=20, REPEAT_PERIOD=5, ch0 held -> initial pulse, next pulse 20 cycles later, then every 5 cycles; release stops pulses.
REQ-036 All N channels rise on the same edge -> all out_pulse bits active in the same cycle, single out_any pulse.
REQ-037 rst_n pulsed low mid-repeat with in_trig held high -> outputs go inactive immediately; one pulse DB_CYCLES+3 edges after release.

Source files
------------

// File: rtl/key_pulse_gen.sv
// Multi-channel key/trigger conditioner: synchronize, debounce, edge-detect and
// optionally auto-repeat, producing one-cycle pulses of selectable polarity.
module key_pulse_gen #(
    parameter int N              = 4,
    parameter int DB_CYCLES      = 16,
    parameter int EDGE_MODE      = 0,
    parameter int REPEAT_EN      = 0,
    parameter int REPEAT_DELAY   = 1000,
    parameter int REPEAT_PERIOD  = 250,
    parameter int OUT_ACTIVE_LOW = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in_trig,
    input  logic         en,
    output logic [N-1:0] out_pulse,
    output logic         out_any,
    output logic [N-1:0] level
);

    localparam int DB_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [RPT_W-1:0] RD_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RP_LAST = RPT_W'(REPEAT_PERIOD - 1);
    localparam logic             ACT_LOW = (OUT_ACTIVE_LOW != 0);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rpt_state_t;

    logic [N-1:0] sync1_reg, sync2_reg;
    logic [N-1:0] stable;
    logic [N-1:0] stable_d_reg;
    logic [N-1:0] rise, fall, edge_q;
    logic [N-1:0] rep_fire;
    logic [N-1:0] pulse_next;
    logic [N-1:0] pulse_reg;
    logic         any_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg    <= '0;
            sync2_reg    <= '0;
            stable_d_reg <= '0;
        end else begin
            sync1_reg    <= in_trig;
            sync2_reg    <= sync1_reg;
            stable_d_reg <= stable;
        end
    end

    always_comb begin
        rise = stable & ~stable_d_reg;
        fall = ~stable & stable_d_reg;
        case (EDGE_MODE)
            0:       edge_q = rise;
            1:       edge_q = fall;
            default: edge_q = rise | fall;
        endcase
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ch
            logic            stable_reg;
            logic [DB_W-1:0] db_cnt_reg;

            // Counter only advances while the synchronized input disagrees with the level.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stable_reg <= 1'b0;
                    db_cnt_reg <= '0;
                end else if (sync2_reg[gi] == stable_reg) begin
                    db_cnt_reg <= '0;
                end else if (db_cnt_reg == DB_LAST) begin
                    stable_reg <= sync2_reg[gi];
                    db_cnt_reg <= '0;
                end else begin
                    db_cnt_reg <= db_cnt_reg + 1'b1;
                end
            end

            assign stable[gi] = stable_reg;

            if (REPEAT_EN != 0) begin : g_rpt
                rpt_state_t       state_reg, state_next;
                logic [RPT_W-1:0] hold_cnt_reg, hold_cnt_next;
                logic             fire;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        state_reg    <= IDLE;
                        hold_cnt_reg <= '0;
                    end else begin
                        state_reg    <= state_next;
                        hold_cnt_reg <= hold_cnt_next;
                    end
                end

                always_comb begin
                    state_next    = state_reg;
                    hold_cnt_next = hold_cnt_reg;
                    fire          = 1'b0;
                    if (!stable_reg || !en) begin
                        state_next    = IDLE;
                        hold_cnt_next = '0;
                    end else begin
                        case (state_reg)
                            IDLE: begin
                                if (rise[gi]) begin
                                    state_next    = HOLD;
                                    hold_cnt_next = '0;
                                end
                            end
                            HOLD: begin
                                if (hold_cnt_reg == RD_LAST) begin
                                    state_next    = REPEAT;
                                    hold_cnt_next = '0;
                                    fire          = 1'b1;
                                end else begin
                                    hold_cnt_next = hold_cnt_reg + 1'b1;
                                end
                            end
                            REPEAT: begin
                                if (hold_cnt_reg == RP_LAST) begin
                                    hold_cnt_next = '0;
                                    fire          = 1'b1;
                                end else begin
                                    hold_cnt_next = hold_cnt_reg + 1'b1;
                                end
                            end
                            default: begin
                                state_next    = IDLE;
                                hold_cnt_next = '0;
                            end
                        endcase
                    end
                end

                assign rep_fire[gi] = fire;
            end else begin : g_no_rpt
                assign rep_fire[gi] = 1'b0;
            end
        end
    endgenerate

    // Edge and repeat requests merge into one pulse; en gates both.
    assign pulse_next = en ? (edge_q | rep_fire) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_reg <= {N{ACT_LOW}};
            any_reg   <= ACT_LOW;
        end else begin
            pulse_reg <= ACT_LOW ? ~pulse_next : pulse_next;
            any_reg   <= ACT_LOW ? ~(|pulse_next) : (|pulse_next);
        end
    end

    assign out_pulse = pulse_reg;
    assign out_any   = any_reg;
    assign level     = stable;

endmodule

// File: tb/tb_key_pulse_gen.sv
// Directed bench for key_pulse_gen: three instances cover default, both-edge
// active-high, and auto-repeat configurations.
module tb_key_pulse_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] trig_a, trig_b, trig_c;
    logic [3:0] out_pulse_a, out_pulse_b, out_pulse_c;
    logic       out_any_a, out_any_b, out_any_c;
    logic [3:0] level_a, level_b, level_c;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    key_pulse_gen ua (
        .clk(clk), .rst_n(rst_n), .in_trig(trig_a), .en(en),
        .out_pulse(out_pulse_a), .out_any(out_any_a), .level(level_a)
    );

    key_pulse_gen #(.EDGE_MODE(2), .OUT_ACTIVE_LOW(0)) ub (
        .clk(clk), .rst_n(rst_n), .in_trig(trig_b), .en(en),
        .out_pulse(out_pulse_b), .out_any(out_any_b), .level(level_b)
    );

    key_pulse_gen #(.REPEAT_EN(1), .REPEAT_DELAY(20), .REPEAT_PERIOD(5)) uc (
        .clk(clk), .rst_n(rst_n), .in_trig(trig_c), .en(en),
        .out_pulse(out_pulse_c), .out_any(out_any_c), .level(level_c)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit rpt_fire(input int k, input int last);
        return (k == 19) || (k >= 39 && k <= last && ((k - 39) % 5) == 0);
    endfunction

    initial begin
        rst_n  = 1'b0;
        en     = 1'b1;
        trig_a = '0;
        trig_b = '0;
        trig_c = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_a_pulse", 32'(out_pulse_a), 32'hF);
        check_eq("rst_a_any",   32'(out_any_a),   32'h1);
        check_eq("rst_a_level", 32'(level_a),     32'h0);
        check_eq("rst_b_pulse", 32'(out_pulse_b), 32'h0);
        check_eq("rst_b_any",   32'(out_any_b),   32'h0);
        check_eq("rst_c_pulse", 32'(out_pulse_c), 32'hF);
        $display("reset state checked");
        @(negedge clk);
        rst_n = 1'b1;

        // Single rising edge on ch0: pulse at edge 19, level from 18.
        trig_a = 4'b0001;
        for (int k = 1; k <= 25; k++) begin
            tick();
            check_eq("a_rise_pulse", 32'(out_pulse_a), (k == 19) ? 32'hE : 32'hF);
            check_eq("a_rise_any",   32'(out_any_a),   (k == 19) ? 32'h0 : 32'h1);
            check_eq("a_rise_level", 32'(level_a),     (k >= 18) ? 32'h1 : 32'h0);
        end
        $display("ch0 rising edge done");

        // 10-cycle glitch on ch1 is rejected.
        trig_a = 4'b0011;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 10) trig_a = 4'b0001;
            check_eq("a_glitch_pulse", 32'(out_pulse_a), 32'hF);
            check_eq("a_glitch_level", 32'(level_a),     32'h1);
        end
        $display("ch1 glitch done");

        // Falling edge in rising-only mode gives no pulse.
        trig_a = 4'b0000;
        for (int k = 1; k <= 22; k++) begin
            tick();
            check_eq("a_fall_pulse", 32'(out_pulse_a), 32'hF);
            check_eq("a_fall_level", 32'(level_a),     (k >= 18) ? 32'h0 : 32'h1);
        end
        $display("ch0 falling edge done");

        // All channels together.
        trig_a = 4'b1111;
        for (int k = 1; k <= 22; k++) begin
            tick();
            check_eq("a_all_pulse", 32'(out_pulse_a), (k == 19) ? 32'h0 : 32'hF);
            check_eq("a_all_any",   32'(out_any_a),   (k == 19) ? 32'h0 : 32'h1);
            check_eq("a_all_level", 32'(level_a),     (k >= 18) ? 32'hF : 32'h0);
        end
        trig_a = 4'b0000;
        for (int k = 1; k <= 22; k++) begin
            tick();
            check_eq("a_allrel_pulse", 32'(out_pulse_a), 32'hF);
            check_eq("a_allrel_level", 32'(level_a),     (k >= 18) ? 32'h0 : 32'hF);
        end
        $display("all-channel edge done");

        // Edge while disabled never pulses, even after en returns.
        en     = 1'b0;
        trig_a = 4'b1000;
        for (int k = 1; k <= 40; k++) begin
            tick();
            check_eq("a_en_pulse", 32'(out_pulse_a), 32'hF);
            check_eq("a_en_any",   32'(out_any_a),   32'h1);
            check_eq("a_en_level", 32'(level_a),     (k >= 18) ? 32'h8 : 32'h0);
            if (k == 25) en = 1'b1;
        end
        $display("enable gating done");

        // Both-edge, active-high instance: press then release on ch2.
        trig_b = 4'b0100;
        for (int k = 1; k <= 22; k++) begin
            tick();
            check_eq("b_press_pulse", 32'(out_pulse_b), (k == 19) ? 32'h4 : 32'h0);
            check_eq("b_press_any",   32'(out_any_b),   (k == 19) ? 32'h1 : 32'h0);
            check_eq("b_press_level", 32'(level_b),     (k >= 18) ? 32'h4 : 32'h0);
        end
        trig_b = 4'b0000;
        for (int k = 1; k <= 22; k++) begin
            tick();
            check_eq("b_rel_pulse", 32'(out_pulse_b), (k == 19) ? 32'h4 : 32'h0);
            check_eq("b_rel_any",   32'(out_any_b),   (k == 19) ? 32'h1 : 32'h0);
            check_eq("b_rel_level", 32'(level_b),     (k >= 18) ? 32'h0 : 32'h4);
        end
        $display("both-edge press/release done");

        // Auto-repeat: 19, 39, then every 5; release after edge 62 drops level at 80.
        trig_c = 4'b0001;
        for (int k = 1; k <= 110; k++) begin
            tick();
            check_eq("c_rpt_pulse", 32'(out_pulse_c), rpt_fire(k, 79) ? 32'hE : 32'hF);
            check_eq("c_rpt_any",   32'(out_any_c),   rpt_fire(k, 79) ? 32'h0 : 32'h1);
            check_eq("c_rpt_level", 32'(level_c),     (k >= 18 && k < 80) ? 32'h1 : 32'h0);
            if (k == 62) trig_c = 4'b0000;
        end
        $display("auto-repeat hold/release done");

        // Reset mid-repeat, input held: immediate inactive, fresh sequence afterwards.
        trig_c = 4'b0001;
        for (int k = 1; k <= 49; k++) begin
            tick();
            check_eq("d_pre_pulse", 32'(out_pulse_c), rpt_fire(k, 1000) ? 32'hE : 32'hF);
        end
        rst_n = 1'b0;
        #1;
        check_eq("d_rst_pulse", 32'(out_pulse_c), 32'hF);
        check_eq("d_rst_any",   32'(out_any_c),   32'h1);
        check_eq("d_rst_level", 32'(level_c),     32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            tick();
            check_eq("d_post_pulse", 32'(out_pulse_c), rpt_fire(k, 1000) ? 32'hE : 32'hF);
            check_eq("d_post_level", 32'(level_c),     (k >= 18) ? 32'h1 : 32'h0);
        end
        $display("reset mid-repeat done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
